// File: rtl/reg_bus_sequencer_pkg.sv
// Shared definitions for the operand-bus sequencer: FSM encoding and default widths.
package reg_bus_sequencer_pkg;

  localparam int DEFAULT_SEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // Index width for a pool of n requesters; a single requester still needs one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_bus_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: searches from rr_ptr+1 (mod NREQ) for the first valid request.
module rr_arbiter
  import reg_bus_sequencer_pkg::*;
#(
  parameter  int NREQ  = 2,
  localparam int PTR_W = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0]  req_valid,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic             grant_valid,
  output logic [PTR_W-1:0] grant_idx
);

  logic [PTR_W-1:0] w_idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    w_idx       = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_idx = PTR_W'((int'(rr_ptr) + i) % NREQ);
      if (!grant_valid && req_valid[w_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = w_idx;
      end
    end
  end

endmodule

// File: rtl/reg_bus_sequencer.sv
// Operand-bus sequencer: round-robin register-to-register moves in fixed three-cycle slots.
// Optional transfer/reject counters are enabled by defining REG_BUS_XFER_COUNT_EN.
module reg_bus_sequencer
  import reg_bus_sequencer_pkg::*;
#(
  parameter  int NREG  = 4,
  parameter  int NREQ  = 2,
  parameter  int SEL_W = DEFAULT_SEL_W,
  localparam int PTR_W = ptr_width(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*SEL_W-1:0] req_src,
  input  logic [NREQ*SEL_W-1:0] req_dst,
  output logic [NREQ-1:0]       req_ack,
  output logic [NREQ-1:0]       req_err,
  output logic [NREQ-1:0]       xfer_done,
  output logic [NREG-1:0]       reg_oe,
  output logic [NREG-1:0]       reg_load,
  output logic                  busy
`ifdef REG_BUS_XFER_COUNT_EN
  ,
  output logic [7:0]            xfer_count,
  output logic [3:0]            err_count
`endif
);

  state_t           r_state, w_next_state;
  logic [PTR_W-1:0] r_rr_ptr, w_next_ptr;
  logic [PTR_W-1:0] r_winner, w_next_winner;
  logic [SEL_W-1:0] r_src, r_dst, w_next_src, w_next_dst;
  logic [SEL_W-1:0] w_req_src, w_req_dst;
  logic             w_grant_valid, w_reject;
  logic [PTR_W-1:0] w_grant_idx;
  logic [NREQ-1:0]  w_next_ack, w_next_err, w_next_done;
  logic [NREG-1:0]  w_next_oe, w_next_load;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_valid  (req_valid),
    .rr_ptr     (r_rr_ptr),
    .grant_valid(w_grant_valid),
    .grant_idx  (w_grant_idx)
  );

  always_comb begin
    w_req_src = '0;
    w_req_dst = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_idx == PTR_W'(i)) begin
        w_req_src = req_src[i*SEL_W +: SEL_W];
        w_req_dst = req_dst[i*SEL_W +: SEL_W];
      end
    end
    w_reject = (w_req_src == w_req_dst) || (int'(w_req_src) >= NREG) ||
               (int'(w_req_dst) >= NREG);
  end

  // Outputs are computed one cycle ahead so every port leaves a flop.
  always_comb begin
    w_next_state  = r_state;
    w_next_ptr    = r_rr_ptr;
    w_next_winner = r_winner;
    w_next_src    = r_src;
    w_next_dst    = r_dst;
    w_next_ack    = '0;
    w_next_err    = '0;
    w_next_done   = '0;
    w_next_oe     = '0;
    w_next_load   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) begin
          w_next_ptr    = w_grant_idx;
          w_next_winner = w_grant_idx;
          if (w_reject) begin
            w_next_err = NREQ'(1) << w_grant_idx;
          end else begin
            w_next_state = ST_DRIVE;
            w_next_src   = w_req_src;
            w_next_dst   = w_req_dst;
            w_next_ack   = NREQ'(1) << w_grant_idx;
            w_next_oe    = NREG'(1) << w_req_src;
          end
        end
      end
      ST_DRIVE: begin
        w_next_state = ST_LOAD;
        w_next_oe    = NREG'(1) << r_src;
        w_next_load  = NREG'(1) << r_dst;
      end
      ST_LOAD: begin
        w_next_state = ST_IDLE;
        w_next_done  = NREQ'(1) << r_winner;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Reset clears the bus strobes immediately so an interrupted move never completes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= PTR_W'(NREQ - 1);
      r_winner  <= '0;
      r_src     <= '0;
      r_dst     <= '0;
      req_ack   <= '0;
      req_err   <= '0;
      xfer_done <= '0;
      reg_oe    <= '0;
      reg_load  <= '0;
      busy      <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_rr_ptr  <= w_next_ptr;
      r_winner  <= w_next_winner;
      r_src     <= w_next_src;
      r_dst     <= w_next_dst;
      req_ack   <= w_next_ack;
      req_err   <= w_next_err;
      xfer_done <= w_next_done;
      reg_oe    <= w_next_oe;
      reg_load  <= w_next_load;
      busy      <= (w_next_state != ST_IDLE);
    end
  end

`ifdef REG_BUS_XFER_COUNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      xfer_count <= '0;
      err_count  <= '0;
    end else begin
      if (|w_next_done) xfer_count <= xfer_count + 8'd1;
      if ((|w_next_err) && (err_count != 4'hF)) err_count <= err_count + 4'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Randomized bench for reg_bus_sequencer checked against a slot-schedule reference model.
// Counter checks are compiled in when REG_BUS_XFER_COUNT_EN is defined.
module tb_reg_bus_sequencer;

  localparam int NREG  = 4;
  localparam int NREQ  = 2;
  localparam int SEL_W = 3;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*SEL_W-1:0] req_src = '0;
  logic [NREQ*SEL_W-1:0] req_dst = '0;
  logic [NREQ-1:0]       req_ack, req_err, xfer_done;
  logic [NREG-1:0]       reg_oe, reg_load;
  logic                  busy;
`ifdef REG_BUS_XFER_COUNT_EN
  logic [7:0]            xfer_count;
  logic [3:0]            err_count;
`endif

  reg_bus_sequencer #(.NREG(NREG), .NREQ(NREQ), .SEL_W(SEL_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_src   (req_src),
    .req_dst   (req_dst),
    .req_ack   (req_ack),
    .req_err   (req_err),
    .xfer_done (xfer_done),
    .reg_oe    (reg_oe),
    .reg_load  (reg_load),
    .busy      (busy)
`ifdef REG_BUS_XFER_COUNT_EN
    ,
    .xfer_count(xfer_count),
    .err_count (err_count)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: expected outputs scheduled per future cycle in a small ring.
  int              edgeCount = 0;
  int              freeEdge  = 0;
  int              modelPtr  = NREQ - 1;
  int              modelXfer = 0;
  int              modelErr  = 0;
  logic [NREG-1:0] expOe[8];
  logic [NREG-1:0] expLoad[8];
  logic [NREQ-1:0] expAck[8];
  logic [NREQ-1:0] expErr[8];
  logic [NREQ-1:0] expDone[8];
  logic            expBusy[8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearSlot(input int s);
    expOe[s]   = '0;
    expLoad[s] = '0;
    expAck[s]  = '0;
    expErr[s]  = '0;
    expDone[s] = '0;
    expBusy[s] = 1'b0;
  endtask

  task automatic resetModel();
    for (int s = 0; s < 8; s++) clearSlot(s);
    modelPtr  = NREQ - 1;
    freeEdge  = 0;
    modelXfer = 0;
    modelErr  = 0;
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] v, input int s0, input int d0,
                               input int s1, input int d1);
    req_valid = v;
    req_src   = {SEL_W'(s1), SEL_W'(s0)};
    req_dst   = {SEL_W'(d1), SEL_W'(d0)};
  endtask

  // At each rising edge where the bus is free, pick the next valid requester in rotation.
  task automatic modelEdge();
    int  w, src, dst, idx;
    bit  found;
    found = 1'b0;
    w     = 0;
    if (reset && edgeCount >= freeEdge) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (modelPtr + k) % NREQ;
        if (!found && req_valid[idx]) begin
          found = 1'b1;
          w     = idx;
        end
      end
      if (found) begin
        modelPtr = w;
        src = int'(req_src[w*SEL_W +: SEL_W]);
        dst = int'(req_dst[w*SEL_W +: SEL_W]);
        if (src == dst || src >= NREG || dst >= NREG) begin
          expErr[edgeCount % 8] = NREQ'(1 << w);
          freeEdge = edgeCount + 1;
        end else begin
          expAck[edgeCount % 8]        = NREQ'(1 << w);
          expOe[edgeCount % 8]         = NREG'(1 << src);
          expBusy[edgeCount % 8]       = 1'b1;
          expOe[(edgeCount + 1) % 8]   = NREG'(1 << src);
          expLoad[(edgeCount + 1) % 8] = NREG'(1 << dst);
          expBusy[(edgeCount + 1) % 8] = 1'b1;
          expDone[(edgeCount + 2) % 8] = NREQ'(1 << w);
          freeEdge = edgeCount + 3;
        end
      end
    end
  endtask

  task automatic checkOutput();
    int s;
    s = edgeCount % 8;
    if (reset && expDone[s] != '0) modelXfer = (modelXfer + 1) % 256;
    if (reset && expErr[s] != '0 && modelErr < 15) modelErr++;
    check("reg_oe", 32'(reg_oe), 32'(expOe[s]));
    check("reg_load", 32'(reg_load), 32'(expLoad[s]));
    check("req_ack", 32'(req_ack), 32'(expAck[s]));
    check("req_err", 32'(req_err), 32'(expErr[s]));
    check("xfer_done", 32'(xfer_done), 32'(expDone[s]));
    check("busy", 32'(busy), 32'(expBusy[s]));
    check("oe_onehot0", 32'($onehot0(reg_oe)), 32'd1);
    check("load_needs_oe", 32'((reg_load != '0) && (reg_oe == '0)), 32'd0);
`ifdef REG_BUS_XFER_COUNT_EN
    check("xfer_count", 32'(xfer_count), 32'(modelXfer));
    check("err_count", 32'(err_count), 32'(modelErr));
`endif
    clearSlot(s);
    edgeCount++;
  endtask

  task automatic tick();
    @(posedge clock);
    modelEdge();
    #1;
    checkOutput();
  endtask

  initial begin
    int v, s0, d0, s1, d1;
    resetModel();
    for (int s = 0; s < 8; s++) clearSlot(s);

    // Held in reset: every output must sit at zero.
    applyStimulus(2'b11, 0, 2, 3, 1);
    tick();
    tick();
    reset = 1'b1;
    applyStimulus(2'b00, 0, 0, 0, 0);
    tick();

    // Single move r0: 1 -> 3.
    applyStimulus(2'b01, 1, 3, 0, 0);
    tick();
    applyStimulus(2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();

    // Both requesters continuously: strict alternation starting from r1 after r0 went last.
    applyStimulus(2'b11, 0, 2, 3, 1);
    for (int i = 0; i < 12; i++) tick();
    applyStimulus(2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();

    // r0 rejected (src == dst), then a simultaneous request must go to r1.
    applyStimulus(2'b01, 2, 2, 0, 0);
    tick();
    applyStimulus(2'b11, 0, 2, 3, 1);
    for (int i = 0; i < 3; i++) tick();
    applyStimulus(2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();

    // Out-of-range destination on r1.
    applyStimulus(2'b10, 0, 0, 1, 5);
    tick();
    applyStimulus(2'b00, 0, 0, 0, 0);
    tick();

    // Randomized traffic with occasional illegal indices.
    for (int i = 0; i < 400; i++) begin
      v  = int'($urandom_range(0, 3));
      s0 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
      d0 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
      s1 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
      d1 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
      applyStimulus(NREQ'(v), s0, d0, s1, d1);
      tick();
    end
    applyStimulus(2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();

    // Reset during LOAD: strobes must drop without a clock edge, and no done follows.
    applyStimulus(2'b10, 0, 0, 2, 1);
    tick();
    applyStimulus(2'b00, 0, 0, 0, 0);
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("async_reg_oe", 32'(reg_oe), 32'd0);
    check("async_reg_load", 32'(reg_load), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    resetModel();
    tick();
    reset = 1'b1;
    applyStimulus(2'b11, 3, 0, 1, 2);
    for (int i = 0; i < 6; i++) tick();
    applyStimulus(2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();

`ifdef REG_BUS_XFER_COUNT_EN
    // Counter wrap and saturation from a clean reset.
    reset = 1'b0;
    #1;
    resetModel();
    tick();
    reset = 1'b1;
    applyStimulus(2'b01, 0, 1, 0, 0);
    for (int i = 0; i < 257 * 3; i++) tick();
    applyStimulus(2'b00, 0, 0, 0, 0);
    tick();
    check("xfer_count_wrap", 32'(xfer_count), 32'd1);
    applyStimulus(2'b01, 2, 2, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    applyStimulus(2'b00, 0, 0, 0, 0);
    tick();
    check("err_count_sat", 32'(err_count), 32'd15);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
